regfile_read_arbiter: RTL and testbench



---
 rtl/tomasulo_pkg.sv | 24 ++
 rtl/regfile_read_arbiter_rr_arbiter.sv | 38 +++
 rtl/regfile_read_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_read_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared widths, types and the round-robin pointer helper for the issue-stage
// register read path.
package tomasulo_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int NUM_REQ = 4;

    typedef logic [ADDR_W-1:0]          reg_addr_t;
    typedef logic [DATA_W-1:0]          reg_data_t;
    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

    // Next round-robin pointer: the slot just after the winner, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        if (idx + 32'd1 >= n) begin
            nxt = 32'd0;
        end else begin
            nxt = idx + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward (mod NUM_REQ) and returns a
// one-hot grant plus the encoded winner; en=0 suppresses every grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    // Priority scan starting at ptr; first requester found wins.
    always_comb begin
        logic found;
        gnt   = {NUM_REQ{1'b0}};
        idx   = {ID_W{1'b0}};
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end else begin
                j = j;
            end
            if (en && req[j] && !found) begin
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
                found  = 1'b1;
            end else begin
                found  = found;
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register-file read port among NUM_REQ requesters with a two-stage
// tagged response pipeline. Optional write-back bypass: REGREAD_BYPASS_EN.
module regfile_read_arbiter
    import tomasulo_pkg::*;
#(
    parameter int NUM_REQ = tomasulo_pkg::NUM_REQ,
    parameter int DATA_W  = tomasulo_pkg::DATA_W,
    parameter int ADDR_W  = tomasulo_pkg::ADDR_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      flush,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [DATA_W-1:0]         rd_data,
`ifdef REGREAD_BYPASS_EN
    input  logic                      wb_valid,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
`endif
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data
);

    logic [ID_W-1:0]    r_ptr;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_s1_valid;
    logic [ID_W-1:0]    r_s1_id;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_data;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_rsp_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req (req),
        .ptr (r_ptr),
        .en  (~flush),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    assign w_any      = |w_gnt;
    assign w_sel_addr = req_addr[int'(w_idx)*ADDR_W +: ADDR_W];

    // Response data select: address 0 reads as zero regardless of the mux.
    always_comb begin
        w_rsp_data = rd_data;
        if (r_rd_addr == {ADDR_W{1'b0}}) begin
            w_rsp_data = {DATA_W{1'b0}};
`ifdef REGREAD_BYPASS_EN
        end else if (wb_valid && (wb_addr == r_rd_addr)) begin
            w_rsp_data = wb_data;
`endif
        end else begin
            w_rsp_data = rd_data;
        end
    end

    // Round-robin pointer and stage A (address issue) registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= {ID_W{1'b0}};
            r_rd_addr  <= {ADDR_W{1'b0}};
            r_s1_valid <= 1'b0;
            r_s1_id    <= {ID_W{1'b0}};
        end else begin
            r_s1_valid <= w_any;
            if (w_any) begin
                r_ptr     <= ID_W'(rr_next(32'(w_idx), 32'(NUM_REQ)));
                r_rd_addr <= w_sel_addr;
                r_s1_id   <= w_idx;
            end else begin
                r_ptr     <= r_ptr;
                r_rd_addr <= r_rd_addr;
                r_s1_id   <= r_s1_id;
            end
        end
    end

    // Stage B: capture read data; a flush kills the in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= {ID_W{1'b0}};
            r_rsp_data  <= {DATA_W{1'b0}};
        end else begin
            r_rsp_valid <= r_s1_valid & ~flush;
            r_rsp_id    <= r_s1_id;
            r_rsp_data  <= w_rsp_data;
        end
    end

    assign gnt       = w_gnt;
    assign rd_addr   = r_rd_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed self-checking bench for regfile_read_arbiter; define
// REGREAD_BYPASS_EN to exercise the write-back bypass ports.
module tb_regfile_read_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic                      flush;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DATA_W-1:0]         rd_data;
    logic                      wb_valid;
    logic [ADDR_W-1:0]         wb_addr;
    logic [DATA_W-1:0]         wb_data;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;

    logic [DATA_W-1:0] regs [0:7];
    int checks;
    int errors;

    assign rd_data = regs[rd_addr];

    regfile_read_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .flush     (flush),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
`ifdef REGREAD_BYPASS_EN
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
`endif
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        flush = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] bypass_exp;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_addr = {NUM_REQ*ADDR_W{1'b0}};
        flush    = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = 3'd0;
        wb_data  = 16'h0000;
        for (int r = 0; r < 8; r++) regs[r] = 16'hA000 | 16'(r);
        regs[0] = 16'hDEAD;
        regs[3] = 16'h1234;
        do_reset();
        #1;

        // Reset state
        check_eq("rst_rd_addr",   32'(rd_addr),   32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_id",    32'(rsp_id),    32'd0);
        check_eq("rst_rsp_data",  32'(rsp_data),  32'd0);
        check_eq("rst_gnt_idle",  32'(gnt),       32'd0);

        // Single read of R3 by requester 0
        req = 4'b0001; req_addr = {3'd0, 3'd0, 3'd0, 3'd3};
        #1;
        check_eq("t1_gnt", 32'(gnt), 32'h1);
        step();
        req = 4'b0000;
        #1;
        check_eq("t1_rd_addr",   32'(rd_addr),   32'd3);
        check_eq("t1_c1_valid",  32'(rsp_valid), 32'd0);
        step();
        check_eq("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("t1_rsp_id",    32'(rsp_id),    32'd0);
        check_eq("t1_rsp_data",  32'(rsp_data),  32'h1234);

        // All four requesting for 8 cycles from ptr=0
        do_reset();
        regs[3]  = 16'hA003;
        req_addr = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int k = 0; k < 10; k++) begin
            req = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) check_eq($sformatf("t2_gnt_%0d", k), 32'(gnt), 32'(1 << (k % 4)));
            if (k >= 2) begin
                check_eq($sformatf("t2_valid_%0d", k), 32'(rsp_valid), 32'd1);
                check_eq($sformatf("t2_id_%0d", k),    32'(rsp_id),    32'((k - 2) % 4));
                check_eq($sformatf("t2_data_%0d", k),  32'(rsp_data),  32'(16'hA000 | 16'((k - 2) % 4 + 1)));
            end
            step();
        end

        // Zero register read while every other register is all ones
        for (int r = 0; r < 8; r++) regs[r] = 16'hFFFF;
        req = 4'b0100; req_addr = {3'd0, 3'd0, 3'd0, 3'd0};
        #1;
        check_eq("t3_gnt", 32'(gnt), 32'h4);
        step();
        req = 4'b0000;
        step();
        check_eq("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("t3_rsp_id",    32'(rsp_id),    32'd2);
        check_eq("t3_rsp_data",  32'(rsp_data),  32'h0000);

        // Flush the cycle after a grant (ptr is 3 here)
        regs[5] = 16'h0055;
        req = 4'b1000; req_addr = {3'd5, 3'd0, 3'd0, 3'd0};
        #1;
        check_eq("t4_gnt", 32'(gnt), 32'h8);
        step();
        req = 4'b0001; flush = 1'b1;
        #1;
        check_eq("t4_flush_gnt", 32'(gnt), 32'h0);
        step();
        flush = 1'b0; req = 4'b0000;
        #1;
        check_eq("t4_no_rsp", 32'(rsp_valid), 32'd0);
        req = 4'b1111;
        #1;
        check_eq("t4_ptr_held", 32'(gnt), 32'h1);
        step();
        req = 4'b0000;
        step();
        step();

        // Reset the cycle after a grant (ptr is 1 here)
        req = 4'b0010; req_addr = {3'd0, 3'd0, 3'd6, 3'd0};
        #1;
        check_eq("t5_gnt", 32'(gnt), 32'h2);
        step();
        req = 4'b0000; rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid",   32'(rsp_valid), 32'd0);
        check_eq("t5_rst_rd_addr", 32'(rd_addr),   32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("t5_post_valid", 32'(rsp_valid), 32'd0);
        step();
        check_eq("t5_post_valid2", 32'(rsp_valid), 32'd0);
        check_eq("t5_post_rd_addr", 32'(rd_addr), 32'd0);
        req = 4'b1111;
        #1;
        check_eq("t5_ptr_zero", 32'(gnt), 32'h1);
        step();
        req = 4'b0000;
        step();
        step();

        // Write-back collision on R5 during stage B (ptr is 1 here)
        regs[5] = 16'h0011;
`ifdef REGREAD_BYPASS_EN
        bypass_exp = 16'h00AA;
`else
        bypass_exp = 16'h0011;
`endif
        req = 4'b0010; req_addr = {3'd0, 3'd0, 3'd5, 3'd0};
        #1;
        check_eq("t6_gnt", 32'(gnt), 32'h2);
        step();
        req = 4'b0000;
        wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'h00AA;
        step();
        wb_valid = 1'b0;
        check_eq("t6_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("t6_rsp_id",    32'(rsp_id),    32'd1);
        check_eq("t6_rsp_data",  32'(rsp_data),  32'(bypass_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
